// File: rtl/main_memory.sv
// Word-addressed memory with a fixed request-to-completion latency.
// Operation encoding on req_operation: 0=LOAD, 1=STORE, 2=CLFLUSH, 3=MO_UNKNOWN.
module main_memory #(
    parameter int unsigned LATENCY     = 4,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [1:0]  req_operation,
    input  logic [31:0] req_address,
    input  logic [31:0] req_store_word,
    output logic [31:0] req_loaded_word,
    output logic        req_fulfilled,
    output logic        busy,
    output logic        illegal_op
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;

    localparam logic [1:0] OP_LOAD    = 2'd0;
    localparam logic [1:0] OP_STORE   = 2'd1;
    localparam logic [1:0] OP_UNKNOWN = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      op_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     data_q;
    logic            fire_c;
    logic            unused_addr_bits;

    // Storage powers up cleared and is never touched by reset.
    logic [31:0] mem [DEPTH_WORDS] = '{default: 32'h0};

    // Only the word-index field of the address selects storage; the rest wraps.
    assign unused_addr_bits = ^{req_address[31:AW+2], req_address[1:0]};

    // Completion is combinational on the last busy cycle; a dropped valid or reset kills it.
    assign fire_c          = (state == ST_BUSY) && (cnt == '0) && req_valid && !reset;
    assign req_fulfilled   = fire_c;
    assign req_loaded_word = (fire_c && (op_q == OP_LOAD)) ? mem[idx_q] : 32'h0;
    assign busy            = (state == ST_BUSY);

    // Request FSM: latch on acceptance, count down, complete or abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_q       <= OP_LOAD;
            idx_q      <= '0;
            data_q     <= '0;
            illegal_op <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q   <= req_operation;
                        idx_q  <= req_address[AW+1:2];
                        data_q <= req_store_word;
                        cnt    <= CW'(LATENCY - 1);
                        state  <= ST_BUSY;
                        if (req_operation == OP_UNKNOWN) begin
                            illegal_op <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!req_valid) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Store commits at the end of the completion cycle.
    always_ff @(posedge clk) begin
        if (fire_c && (op_q == OP_STORE)) begin
            mem[idx_q] <= data_q;
        end
    end

endmodule
